aes256_key_schedule_ctrl: RTL and testbench

Iterative AES-256 key-schedule sequencer. Accepts a 256-bit cipher key over a valid/ready handshake and generates round keys 2..14 one per cycle through a single shared round-key stage. Round keys 0..14 are stored internally. The cipher core reads them through a registered read port while the rounds are still being produced.

---
 rtl/aes_pkg.sv | 68 ++++++
 rtl/aes256_key_round.sv | 53 +++++
 rtl/aes_defines.svh | 11 +
 rtl/aes_sbox.sv | 14 +
 rtl/aes256_key_schedule_ctrl.sv | 177 +++++++++++++++++
 tb/tb_aes256_key_schedule_ctrl.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-256 key-schedule definitions: FSM state type, Rcon table and GF(2^8) S-box helpers.
// The optional zeroize feature is enabled with AES256_KSCHED_ZEROIZE_EN (used by the top module).
package aes_pkg;

  localparam int AES256_NUM_ROUND_KEYS = 15;
  localparam logic [3:0] LAST_ROUND_IDX = 4'd14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  localparam logic [7:0] RCON_TABLE [1:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  // Rcon word for Rcon index r/2 (only even rounds consume it).
  function automatic logic [31:0] rcon_word(input logic [2:0] rcon_idx);
    logic [31:0] word_v;
    case (rcon_idx)
      3'd1:    word_v = {RCON_TABLE[1], 24'h000000};
      3'd2:    word_v = {RCON_TABLE[2], 24'h000000};
      3'd3:    word_v = {RCON_TABLE[3], 24'h000000};
      3'd4:    word_v = {RCON_TABLE[4], 24'h000000};
      3'd5:    word_v = {RCON_TABLE[5], 24'h000000};
      3'd6:    word_v = {RCON_TABLE[6], 24'h000000};
      3'd7:    word_v = {RCON_TABLE[7], 24'h000000};
      default: word_v = 32'h00000000;
    endcase
    return word_v;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc_v;
    logic [7:0] sh_v;
    acc_v = 8'h00;
    sh_v  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc_v = acc_v ^ sh_v;
      end else begin
        acc_v = acc_v;
      end
      sh_v = {sh_v[6:0], 1'b0} ^ (sh_v[7] ? 8'h1b : 8'h00);
    end
    return acc_v;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] res_v;
    logic [7:0] pow_v;
    logic [7:0] exp_v;
    res_v = 8'h01;
    pow_v = x;
    exp_v = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (exp_v[i]) begin
        res_v = gf_mul(res_v, pow_v);
      end else begin
        res_v = res_v;
      end
      pow_v = gf_mul(pow_v, pow_v);
    end
    return res_v ^ {res_v[6:0], res_v[7]} ^ {res_v[5:0], res_v[7:6]} ^
           {res_v[4:0], res_v[7:5]} ^ {res_v[3:0], res_v[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes256_key_round.sv
// Combinational AES-256 round-key stage: rk[r] from rk[r-2], rk[r-1] and runtime round index r.
`include "aes_defines.svh"

module aes256_key_round
  import aes_pkg::*;
(
  input  logic [`AES_BLOCK_W-1:0] prev2_key,
  input  logic [`AES_BLOCK_W-1:0] prev1_key,
  input  logic [3:0]              round_idx,
  output logic [`AES_BLOCK_W-1:0] round_key
);

  logic [`AES_WORD_W-1:0] last_word_s;
  logic [`AES_WORD_W-1:0] sub_in_s;
  logic [`AES_WORD_W-1:0] sub_out_s;
  logic [`AES_WORD_W-1:0] temp_s;
  logic [`AES_WORD_W-1:0] o0_s;
  logic [`AES_WORD_W-1:0] o1_s;
  logic [`AES_WORD_W-1:0] o2_s;
  logic [`AES_WORD_W-1:0] o3_s;

  // Even rounds rotate the last word before substitution; odd rounds do not.
  always_comb begin
    last_word_s = `AES_WORD(prev1_key, 3);
    if (round_idx[0] == 1'b0) begin
      sub_in_s = {last_word_s[23:0], last_word_s[31:24]};
    end else begin
      sub_in_s = last_word_s;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in_s[8*g +: 8]),
      .out_byte (sub_out_s[8*g +: 8])
    );
  end

  // Rcon applies to even rounds only, then each word chains off the previous output word.
  always_comb begin
    if (round_idx[0] == 1'b0) begin
      temp_s = sub_out_s ^ rcon_word(round_idx[3:1]);
    end else begin
      temp_s = sub_out_s;
    end
    o0_s      = `AES_WORD(prev2_key, 0) ^ temp_s;
    o1_s      = `AES_WORD(prev2_key, 1) ^ o0_s;
    o2_s      = `AES_WORD(prev2_key, 2) ^ o1_s;
    o3_s      = `AES_WORD(prev2_key, 3) ^ o2_s;
    round_key = {o0_s, o1_s, o2_s, o3_s};
  end

endmodule

// File: rtl/aes_defines.svh
// AES word/block widths and a word-slice helper; word 0 is the most significant word.
`ifndef AES_DEFINES_SVH
`define AES_DEFINES_SVH

`define AES_WORD_W  32
`define AES_BLOCK_W 128
`define AES_KEY_W   256

`define AES_WORD(blk, i) blk[`AES_BLOCK_W-1-((i)*`AES_WORD_W) -: `AES_WORD_W]

`endif

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Pure table function of the input byte.
  always_comb begin
    out_byte = sbox_fwd(in_byte);
  end

endmodule

// File: rtl/aes256_key_schedule_ctrl.sv
// Iterative AES-256 key-schedule sequencer with 15-entry round-key store and registered read port.
// Optional AES256_KSCHED_ZEROIZE_EN adds a zeroize input that wipes the store and forces IDLE.
`include "aes_defines.svh"

module aes256_key_schedule_ctrl
  import aes_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  output logic                    key_ready,
  input  logic [`AES_KEY_W-1:0]   key,
  input  logic                    rd_en,
  input  logic [3:0]              rd_index,
  output logic [`AES_BLOCK_W-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    busy,
`ifdef AES256_KSCHED_ZEROIZE_EN
  input  logic                    zeroize,
`endif
  output logic                    schedule_done
);

  ks_state_e state_r;
  ks_state_e state_nxt_s;

  logic [3:0]                       cnt_r;
  logic [AES256_NUM_ROUND_KEYS-1:0] mask_r;
  logic [`AES_BLOCK_W-1:0]          rk_r [0:AES256_NUM_ROUND_KEYS-1];

  logic                    accept_s;
  logic                    expand_wr_s;
  logic                    zeroize_s;
  logic [3:0]              prev1_idx_s;
  logic [3:0]              prev2_idx_s;
  logic [`AES_BLOCK_W-1:0] prev1_key_s;
  logic [`AES_BLOCK_W-1:0] prev2_key_s;
  logic [`AES_BLOCK_W-1:0] round_key_s;

  logic                    key_ready_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    rd_valid_r;
  logic [`AES_BLOCK_W-1:0] rd_data_r;

`ifdef AES256_KSCHED_ZEROIZE_EN
  assign zeroize_s = zeroize;
`else
  assign zeroize_s = 1'b0;
`endif

  assign key_ready     = key_ready_r;
  assign busy          = busy_r;
  assign schedule_done = done_r;
  assign rd_valid      = rd_valid_r;
  assign rd_data       = rd_data_r;

  // Next-state logic; zeroize overrides both key acceptance and the EXPAND write.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    expand_wr_s = 1'b0;
    if (zeroize_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE, READY: begin
          if (key_valid) begin
            accept_s    = 1'b1;
            state_nxt_s = EXPAND;
          end else begin
            state_nxt_s = state_r;
          end
        end
        EXPAND: begin
          expand_wr_s = 1'b1;
          if (cnt_r >= LAST_ROUND_IDX) begin
            state_nxt_s = READY;
          end else begin
            state_nxt_s = EXPAND;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Select the two preceding round keys feeding the shared stage.
  always_comb begin
    if ((cnt_r >= 4'd2) && (cnt_r <= LAST_ROUND_IDX)) begin
      prev1_idx_s = cnt_r - 4'd1;
      prev2_idx_s = cnt_r - 4'd2;
    end else begin
      prev1_idx_s = 4'd0;
      prev2_idx_s = 4'd0;
    end
    prev1_key_s = rk_r[prev1_idx_s];
    prev2_key_s = rk_r[prev2_idx_s];
  end

  aes256_key_round u_round (
    .prev2_key (prev2_key_s),
    .prev1_key (prev1_key_s),
    .round_idx (cnt_r),
    .round_key (round_key_s)
  );

  // State register plus status outputs decoded from the next state so they are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      key_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      key_ready_r <= (state_nxt_s != EXPAND);
      busy_r      <= (state_nxt_s == EXPAND);
      done_r      <= (state_nxt_s == READY);
    end
  end

  // Round-key store, valid mask and round counter; the counter saturates at the last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= 4'd0;
      mask_r <= '0;
      for (int i = 0; i < AES256_NUM_ROUND_KEYS; i++) begin
        rk_r[i] <= '0;
      end
    end else if (zeroize_s) begin
      cnt_r  <= 4'd0;
      mask_r <= '0;
      for (int i = 0; i < AES256_NUM_ROUND_KEYS; i++) begin
        rk_r[i] <= '0;
      end
    end else if (accept_s) begin
      rk_r[0] <= key[255:128];
      rk_r[1] <= key[127:0];
      cnt_r   <= 4'd2;
      mask_r  <= 15'b000_0000_0000_0011;
    end else if (expand_wr_s) begin
      rk_r[cnt_r]   <= round_key_s;
      mask_r[cnt_r] <= 1'b1;
      if (cnt_r < LAST_ROUND_IDX) begin
        cnt_r <= cnt_r + 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered read port; a same-cycle write is not forwarded, so the old mask bit is returned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else if (zeroize_s) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else if (rd_en) begin
      if (rd_index <= LAST_ROUND_IDX) begin
        rd_data_r  <= rk_r[rd_index];
        rd_valid_r <= mask_r[rd_index];
      end else begin
        rd_data_r  <= '0;
        rd_valid_r <= 1'b0;
      end
    end else begin
      rd_data_r  <= rd_data_r;
      rd_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes256_key_schedule_ctrl.sv
// Directed self-checking bench for aes256_key_schedule_ctrl (FIPS-197 AES-256 key vectors).
module tb_aes256_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [255:0] key = '0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_index = 4'd0;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         busy;
  logic         schedule_done;
`ifdef AES256_KSCHED_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [255:0] KEY_A    = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_B    = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] KEY_B_LO = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK2_A    = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] RK14_A   = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] RK2_B    = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] RK3_B    = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
  localparam logic [127:0] RK14_B   = 128'hfe4890d1e6188d0b046df344706c631e;

  aes256_key_schedule_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .key           (key),
    .rd_en         (rd_en),
    .rd_index      (rd_index),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .busy          (busy),
`ifdef AES256_KSCHED_ZEROIZE_EN
    .zeroize       (zeroize),
`endif
    .schedule_done (schedule_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] idx);
    rd_en    = 1'b1;
    rd_index = idx;
    tick();
    rd_en    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!schedule_done && cyc < 40) begin
      tick();
      cyc++;
    end
    total_cnt++;
    if (schedule_done !== 1'b1) $display("FAIL %s_done_timeout: got %b expected 1", tag, schedule_done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (key_ready !== 1'b1) $display("FAIL rst_key_ready: got %b expected 1", key_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (schedule_done !== 1'b0) $display("FAIL rst_done: got %b expected 0", schedule_done); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_data !== 128'h0) $display("FAIL rst_rd_data: got %h expected 0", rd_data); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_schedule_latency();
    int cyc;
    key = KEY_A;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL lat_busy_t1: got %b expected 1", busy); else pass_cnt++;
    total_cnt++; if (key_ready !== 1'b0) $display("FAIL lat_ready_t1: got %b expected 0", key_ready); else pass_cnt++;
    cyc = 1;
    while (!schedule_done && cyc < 40) begin
      tick();
      cyc++;
    end
    total_cnt++; if (cyc !== 14) $display("FAIL lat_done_cycle: got %0d expected 14", cyc); else pass_cnt++;
    total_cnt++; if (key_ready !== 1'b1) $display("FAIL lat_ready_t14: got %b expected 1", key_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL lat_busy_t14: got %b expected 0", busy); else pass_cnt++;
    do_read(4'd14);
    total_cnt++; if (rd_data !== RK14_A) $display("FAIL a_rk14: got %h expected %h", rd_data, RK14_A); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b1) $display("FAIL a_rk14_valid: got %b expected 1", rd_valid); else pass_cnt++;
    do_read(4'd2);
    total_cnt++; if (rd_data !== RK2_A) $display("FAIL a_rk2: got %h expected %h", rd_data, RK2_A); else pass_cnt++;
  endtask

  task automatic test_round2_timing();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    key = KEY_B;
    key_valid = 1'b1;
    rd_en = 1'b1;
    rd_index = 4'd2;
    tick();
    key_valid = 1'b0;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL b_rk2_read_t0: got %b expected 0", rd_valid); else pass_cnt++;
    tick();
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL b_rk2_read_during_write: got %b expected 0", rd_valid); else pass_cnt++;
    tick();
    total_cnt++; if (rd_valid !== 1'b1) $display("FAIL b_rk2_valid: got %b expected 1", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_data !== RK2_B) $display("FAIL b_rk2: got %h expected %h", rd_data, RK2_B); else pass_cnt++;
    rd_index = 4'd1;
    tick();
    total_cnt++; if (rd_data !== KEY_B_LO) $display("FAIL b_rk1: got %h expected %h", rd_data, KEY_B_LO); else pass_cnt++;
    rd_en = 1'b0;
    tick();
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL b_idle_valid: got %b expected 0", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_data !== KEY_B_LO) $display("FAIL b_idle_hold: got %h expected %h", rd_data, KEY_B_LO); else pass_cnt++;
    wait_done("b");
    do_read(4'd3);
    total_cnt++; if (rd_data !== RK3_B) $display("FAIL b_rk3: got %h expected %h", rd_data, RK3_B); else pass_cnt++;
    do_read(4'd14);
    total_cnt++; if (rd_data !== RK14_B) $display("FAIL b_rk14: got %h expected %h", rd_data, RK14_B); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int ready_seen = 0;
    key = KEY_A;
    key_valid = 1'b1;
    tick();
    key = KEY_B;
    for (int i = 1; i <= 13; i++) begin
      if (key_ready !== 1'b0) ready_seen++;
      tick();
    end
    total_cnt++; if (ready_seen !== 0) $display("FAIL b2b_stall: got %0d ready cycles expected 0", ready_seen); else pass_cnt++;
    total_cnt++; if (key_ready !== 1'b1) $display("FAIL b2b_ready_t14: got %b expected 1", key_ready); else pass_cnt++;
    total_cnt++; if (schedule_done !== 1'b1) $display("FAIL b2b_done_t14: got %b expected 1", schedule_done); else pass_cnt++;
    tick();
    key_valid = 1'b0;
    total_cnt++; if (schedule_done !== 1'b0) $display("FAIL b2b_done_clear: got %b expected 0", schedule_done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy_second: got %b expected 1", busy); else pass_cnt++;
    do_read(4'd5);
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL b2b_mask_reset_idx5: got %b expected 0", rd_valid); else pass_cnt++;
    wait_done("b2b");
    do_read(4'd2);
    total_cnt++; if (rd_data !== RK2_B) $display("FAIL b2b_second_key_rk2: got %h expected %h", rd_data, RK2_B); else pass_cnt++;
  endtask

  task automatic test_bad_index_and_collision();
    do_read(4'd15);
    total_cnt++; if (rd_data !== 128'h0) $display("FAIL idx15_data: got %h expected 0", rd_data); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL idx15_valid: got %b expected 0", rd_valid); else pass_cnt++;
    key = KEY_A;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (3) tick();
    rd_en = 1'b1;
    rd_index = 4'd5;
    tick();
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL collide_idx5: got %b expected 0", rd_valid); else pass_cnt++;
    tick();
    rd_en = 1'b0;
    total_cnt++; if (rd_valid !== 1'b1) $display("FAIL after_write_idx5: got %b expected 1", rd_valid); else pass_cnt++;
    wait_done("coll");
  endtask

  task automatic test_reset_mid();
    key = KEY_B;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (key_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b expected 1", key_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (schedule_done !== 1'b0) $display("FAIL mid_rst_done: got %b expected 0", schedule_done); else pass_cnt++;
    total_cnt++; if (rd_data !== 128'h0) $display("FAIL mid_rst_data: got %h expected 0", rd_data); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    do_read(4'd0);
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL post_rst_valid: got %b expected 0", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_data !== 128'h0) $display("FAIL post_rst_data: got %h expected 0", rd_data); else pass_cnt++;
    total_cnt++; if (key_ready !== 1'b1) $display("FAIL post_rst_ready: got %b expected 1", key_ready); else pass_cnt++;
  endtask

`ifdef AES256_KSCHED_ZEROIZE_EN
  task automatic test_zeroize();
    key = KEY_A;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    wait_done("zero");
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    total_cnt++; if (schedule_done !== 1'b0) $display("FAIL zero_done: got %b expected 0", schedule_done); else pass_cnt++;
    total_cnt++; if (key_ready !== 1'b1) $display("FAIL zero_ready: got %b expected 1", key_ready); else pass_cnt++;
    do_read(4'd14);
    total_cnt++; if (rd_data !== 128'h0) $display("FAIL zero_rk14: got %h expected 0", rd_data); else pass_cnt++;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL zero_rk14_valid: got %b expected 0", rd_valid); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_schedule_latency();
    test_round2_timing();
    test_back_to_back();
    test_bad_index_and_collision();
    test_reset_mid();
`ifdef AES256_KSCHED_ZEROIZE_EN
    test_zeroize();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
